// File: rtl/matrix_exec_engine_if.sv
// Shared memory bus between the matrix engine (master) and the
// instruction/data memories (slave).
interface matrix_exec_engine_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 16
);
    logic [DATA_W-1:0] InstructDataOut;
    logic [DATA_W-1:0] MemDataOut;
    logic [DATA_W-1:0] ExeDataOut;
    logic [ADDR_W-1:0] address;
    logic              nRead;
    logic              nWrite;

    modport master (
        input  InstructDataOut, MemDataOut,
        output ExeDataOut, address, nRead, nWrite
    );
    modport slave (
        output InstructDataOut, MemDataOut,
        input  ExeDataOut, address, nRead, nWrite
    );
endinterface

// File: rtl/matrix_exec_engine.sv
// Matrix coprocessor sequencer: fetch, decode, read up to two operands,
// execute a lane-wise or wide integer op, write back, repeat until STOP.
module matrix_exec_engine #(
    parameter int                DATA_W     = 256,
    parameter int                ELEM_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                PC_W       = 8,
    parameter logic [ADDR_W-1:0] INSTR_BASE = 'h8000,
    parameter logic [ADDR_W-1:0] DATA_BASE  = 'h0000,
    parameter int                MEM_LAT    = 2,
    parameter int                WR_CYC     = 2
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic                 run,
    matrix_exec_engine_if.master bus,
    output logic [PC_W-1:0]      pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 error
);
    localparam int LANES   = DATA_W / ELEM_W;
    localparam int HALF    = DATA_W / 2;
    localparam int CNT_MAX = (MEM_LAT > WR_CYC) ? MEM_LAT : WR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [7:0] OP_MADD   = 8'h01;
    localparam logic [7:0] OP_MSUB   = 8'h02;
    localparam logic [7:0] OP_MSCALE = 8'h04;
    localparam logic [7:0] OP_MSCALI = 8'h05;
    localparam logic [7:0] OP_IADD   = 8'h10;
    localparam logic [7:0] OP_ISUB   = 8'h11;
    localparam logic [7:0] OP_IMUL   = 8'h12;
    localparam logic [7:0] OP_STOP   = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_RD1, S_RD2, S_EXEC, S_WR, S_NEXT, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [7:0] op, dest, src1, src2;
    assign op   = instr_q[31:24];
    assign dest = instr_q[23:16];
    assign src1 = instr_q[15:8];
    assign src2 = instr_q[7:0];

    logic unused_instr_hi;
    assign unused_instr_hi = ^bus.InstructDataOut[DATA_W-1:32];

    // Lane datapath: each lane is isolated so carries/borrows never cross.
    logic [LANES-1:0][ELEM_W-1:0] a_l, b_l, add_l, sub_l, mul_l;
    logic [ELEM_W-1:0]            scale;
    logic [DATA_W-1:0]            imul, alu_r;

    assign a_l   = a_q;
    assign b_l   = b_q;
    assign scale = (op == OP_MSCALI) ? ELEM_W'(src2) : b_l[0];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign add_l[i] = a_l[i] + b_l[i];
        assign sub_l[i] = a_l[i] - b_l[i];
        assign mul_l[i] = a_l[i] * scale;
    end

    assign imul = DATA_W'(a_q[HALF-1:0]) * DATA_W'(b_q[HALF-1:0]);

    always_comb begin
        alu_r = '0;
        case (op)
            OP_MADD:              alu_r = add_l;
            OP_MSUB:              alu_r = sub_l;
            OP_MSCALE, OP_MSCALI: alu_r = mul_l;
            OP_IADD:              alu_r = a_q + b_q;
            OP_ISUB:              alu_r = a_q - b_q;
            OP_IMUL:              alu_r = imul;
            default:              alu_r = '0;
        endcase
    end

    logic legal;
    always_comb begin
        case (op)
            OP_MADD, OP_MSUB, OP_MSCALE, OP_MSCALI,
            OP_IADD, OP_ISUB, OP_IMUL: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
    end

    logic              rd_n, wr_n;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] wdata;
    logic              rd_last;
    assign rd_last = (cnt_q == CNT_W'(MEM_LAT));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        pc_d     = pc_q;
        err_d    = err_q;
        bus_addr = addr_q;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        wdata    = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_n     = 1'b0;
                bus_addr = INSTR_BASE + ADDR_W'(pc_q);
                cnt_d    = cnt_q + CNT_W'(1);
                if (rd_last) begin
                    instr_d = bus.InstructDataOut[31:0];
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_STOP) begin
                    state_d = S_HALT;
                end else if (!legal) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                rd_n     = 1'b0;
                bus_addr = DATA_BASE + ADDR_W'(src1);
                cnt_d    = cnt_q + CNT_W'(1);
                if (rd_last) begin
                    a_d     = bus.MemDataOut;
                    cnt_d   = '0;
                    state_d = (op == OP_MSCALI) ? S_EXEC : S_RD2;
                end
            end
            S_RD2: begin
                rd_n     = 1'b0;
                bus_addr = DATA_BASE + ADDR_W'(src2);
                cnt_d    = cnt_q + CNT_W'(1);
                if (rd_last) begin
                    b_d     = bus.MemDataOut;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                r_d     = alu_r;
                state_d = S_WR;
            end
            S_WR: begin
                wr_n     = 1'b0;
                bus_addr = DATA_BASE + ADDR_W'(dest);
                wdata    = r_q;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        addr_d = bus_addr;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.address    = bus_addr;
    assign bus.nRead      = rd_n;
    assign bus.nWrite     = wr_n;
    assign bus.ExeDataOut = wdata;
    assign pc             = pc_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted         = (state_q == S_HALT);
    assign error          = err_q;
endmodule

// File: tb/tb_matrix_exec_engine.sv
// Scoreboarded bench for matrix_exec_engine: memory models with MEM_LAT
// read latency, expected writes queued at program load, popped on write.
module tb_matrix_exec_engine;
    localparam int DW = 256;
    localparam int EW = 16;
    localparam int AW = 16;
    localparam int ML = 2;
    localparam int WC = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          Clk = 1'b0;
    logic          nReset = 1'b0;
    logic          run = 1'b0;
    logic          run2 = 1'b0;
    logic [7:0]    pc;
    logic [1:0]    pc2;
    logic          busy, halted, error, busy2, halted2, error2;

    int n_cmp = 0;
    int n_bad = 0;
    wr_t sb[$];

    always #5 Clk = ~Clk;

    matrix_exec_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    matrix_exec_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    matrix_exec_engine u_dut (
        .Clk(Clk), .nReset(nReset), .run(run), .bus(bus),
        .pc(pc), .busy(busy), .halted(halted), .error(error)
    );

    matrix_exec_engine #(.PC_W(2)) u_dut2 (
        .Clk(Clk), .nReset(nReset), .run(run2), .bus(bus2),
        .pc(pc2), .busy(busy2), .halted(halted2), .error(error2)
    );

    // Memories: read data for the address presented ML cycles earlier.
    logic [DW-1:0] imem [256];
    logic [DW-1:0] imem2 [4];
    logic [DW-1:0] dmem [256];
    logic [AW-1:0] pipe1 [ML];
    logic [AW-1:0] pipe2 [ML];

    always @(posedge Clk) begin
        pipe1[0] <= bus.address;
        pipe2[0] <= bus2.address;
        for (int k = 1; k < ML; k++) begin
            pipe1[k] <= pipe1[k-1];
            pipe2[k] <= pipe2[k-1];
        end
    end

    assign bus.InstructDataOut  = imem[pipe1[ML-1][7:0]];
    assign bus.MemDataOut       = dmem[pipe1[ML-1][7:0]];
    assign bus2.InstructDataOut = imem2[pipe2[ML-1][1:0]];
    assign bus2.MemDataOut      = dmem[pipe2[ML-1][7:0]];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ins(input logic [7:0] op, d, s1, s2);
        return DW'({op, d, s1, s2});
    endfunction

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] model(input logic [7:0] op, input logic [DW-1:0] a, b,
                                            input logic [7:0] imm);
        logic [DW-1:0] r, x, y;
        logic [EW-1:0] ea, eb;
        r = '0;
        for (int i = 0; i < DW / EW; i++) begin
            ea = a[i*EW +: EW];
            eb = b[i*EW +: EW];
            case (op)
                8'h01: r[i*EW +: EW] = ea + eb;
                8'h02: r[i*EW +: EW] = ea - eb;
                8'h04: r[i*EW +: EW] = ea * b[EW-1:0];
                8'h05: r[i*EW +: EW] = ea * {8'h00, imm};
                default: ;
            endcase
        end
        x = {{(DW/2){1'b0}}, a[DW/2-1:0]};
        y = {{(DW/2){1'b0}}, b[DW/2-1:0]};
        case (op)
            8'h10: r = a + b;
            8'h11: r = a - b;
            8'h12: r = x * y;
            default: ;
        endcase
        return r;
    endfunction

    // Bus monitor for the default-parameter engine.
    int   overlap_cnt = 0, leak_cnt = 0, rd_data_cyc = 0, wr_cnt = 0, wr_len = 0;
    logic in_wr = 1'b0;
    wr_t  e;
    always @(negedge Clk) begin
        if (!nReset) begin
            in_wr = 1'b0;
        end else begin
            if (!bus.nRead && !bus.nWrite) overlap_cnt++;
            if (bus.nWrite && bus.ExeDataOut != '0) leak_cnt++;
            if (!bus.nRead && !bus.address[AW-1]) rd_data_cyc++;
            if (!bus.nWrite) begin
                if (!in_wr) begin
                    wr_cnt++;
                    wr_len = 0;
                    chk("wr_expected", DW'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("wr_addr", DW'(bus.address), DW'(e.a));
                        chk("wr_data", bus.ExeDataOut, e.d);
                    end
                end
                in_wr = 1'b1;
                wr_len++;
            end else if (in_wr) begin
                in_wr = 1'b0;
                chk("wr_len", DW'(wr_len), DW'(WC));
            end
        end
    end

    // PC wrap / refetch monitor for the PC_W=2 engine.
    int         fetch0_cnt = 0, wrap_cnt = 0;
    logic       f0, f0_prev = 1'b0;
    logic [1:0] pc2_prev = '0;
    always @(negedge Clk) begin
        f0 = !bus2.nRead && (bus2.address == 16'h8000);
        if (f0 && !f0_prev) fetch0_cnt++;
        f0_prev = f0;
        if (nReset && pc2_prev == 2'd3 && pc2 == 2'd0) wrap_cnt++;
        pc2_prev = pc2;
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = ins(8'hFF, 8'h00, 8'h00, 8'h00);
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset();
        run = 1'b0;
        run2 = 1'b0;
        @(posedge Clk); #1;
        nReset = 1'b0;
        repeat (2) @(negedge Clk);
        @(posedge Clk); #1;
        nReset = 1'b1;
    endtask

    task automatic run_prog(input logic exp_err, input string tag);
        int n;
        n = 0;
        @(negedge Clk);
        run = 1'b1;
        while (!halted && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_halted"}, DW'(halted), 1);
        chk({tag, "_error"}, DW'(error), DW'(exp_err));
        chk({tag, "_sb_empty"}, DW'(sb.size()), 0);
    endtask

    initial begin : stim
        logic [DW-1:0] t3a, t3e;
        logic [7:0]    ops [6];
        int k, rd0, wr0, f0c, w0;
        logic found;

        // Test 1: reset values, IADD 7+9 latency, STOP
        clear_mem();
        imem[0] = ins(8'h10, 8'h05, 8'h01, 8'h02);
        dmem[1] = DW'(7);
        dmem[2] = DW'(9);
        sb.push_back('{16'h0005, DW'(16)});
        nReset = 1'b0;
        run = 1'b1;
        #12;
        chk("rst_nRead", DW'(bus.nRead), 1);
        chk("rst_nWrite", DW'(bus.nWrite), 1);
        chk("rst_address", DW'(bus.address), 0);
        chk("rst_wdata", bus.ExeDataOut, 0);
        chk("rst_pc", DW'(pc), 0);
        chk("rst_flags", DW'({busy, halted, error}), 0);
        @(posedge Clk); #1;
        nReset = 1'b1;
        k = 0;
        while (!busy && k < 20) begin @(negedge Clk); k++; end
        chk("t1_started", DW'(busy), 1);
        k = 0;
        while (pc != 8'd1 && k < 100) begin @(negedge Clk); k++; end
        chk("t1_latency", DW'(k), 14);
        run_prog(1'b0, "t1");
        chk("t1_idle_bus", DW'(busy), 0);

        // Test 2: MADD lanes wrap without inter-lane carry
        do_reset();
        clear_mem();
        imem[0] = ins(8'h01, 8'h06, 8'h03, 8'h04);
        dmem[3] = {16{16'hFFFF}};
        dmem[4] = {16{16'h0002}};
        sb.push_back('{16'h0006, {16{16'h0001}}});
        run_prog(1'b0, "t2");

        // Test 3: MSCALI, single read phase
        do_reset();
        clear_mem();
        for (int i = 0; i < 16; i++) begin
            t3a[i*16 +: 16] = 16'(i);
            t3e[i*16 +: 16] = 16'(3 * i);
        end
        dmem[5] = t3a;
        imem[0] = ins(8'h05, 8'h07, 8'h05, 8'h03);
        sb.push_back('{16'h0007, t3e});
        rd0 = rd_data_cyc;
        run_prog(1'b0, "t3");
        chk("t3_rd_cycles", DW'(rd_data_cyc - rd0), DW'(ML + 1));

        // Test 4: illegal opcode halts with error, no data traffic
        do_reset();
        clear_mem();
        imem[0] = ins(8'h03, 8'h00, 8'h00, 8'h00);
        rd0 = rd_data_cyc;
        wr0 = wr_cnt;
        run_prog(1'b1, "t4");
        chk("t4_no_read", DW'(rd_data_cyc - rd0), 0);
        chk("t4_no_write", DW'(wr_cnt - wr0), 0);
        repeat (10) @(negedge Clk);
        chk("t4_still_halted", DW'({halted, busy, error}), DW'(3'b101));

        // Test 5: reset during the second write, then full re-execution
        do_reset();
        clear_mem();
        imem[0] = ins(8'h10, 8'h05, 8'h01, 8'h02);
        imem[1] = ins(8'h01, 8'h06, 8'h03, 8'h04);
        dmem[1] = DW'(7);
        dmem[2] = DW'(9);
        dmem[3] = {16{16'hFFFF}};
        dmem[4] = {16{16'h0002}};
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{16'h0005, DW'(16)});
            sb.push_back('{16'h0006, {16{16'h0001}}});
        end
        @(negedge Clk);
        run = 1'b1;
        found = 1'b0;
        k = 0;
        while (!found && k < 200) begin
            @(negedge Clk);
            k++;
            found = !bus.nWrite && pc == 8'd1;
        end
        chk("t5_reached_wr", DW'(found), 1);
        @(posedge Clk); #1;
        nReset = 1'b0;
        #1;
        chk("t5_rst_nWrite", DW'(bus.nWrite), 1);
        chk("t5_rst_wdata", bus.ExeDataOut, 0);
        chk("t5_rst_pc", DW'(pc), 0);
        repeat (2) @(negedge Clk);
        @(posedge Clk); #1;
        nReset = 1'b1;
        run_prog(1'b0, "t5");

        // Test 7: mixed ops on random operands against the reference model
        do_reset();
        clear_mem();
        ops = '{8'h02, 8'h04, 8'h11, 8'h12, 8'h10, 8'h05};
        for (int i = 0; i < 6; i++) begin
            dmem[8'h10 + 2*i]     = rnd256();
            dmem[8'h10 + 2*i + 1] = rnd256();
            imem[i] = ins(ops[i], 8'(8'h40 + i), 8'(8'h10 + 2*i), 8'(8'h10 + 2*i + 1));
            sb.push_back('{16'(16'h0040 + i),
                           model(ops[i], dmem[8'h10 + 2*i], dmem[8'h10 + 2*i + 1],
                                 8'(8'h10 + 2*i + 1))});
        end
        run_prog(1'b0, "t7");

        // Test 6: PC_W=2 engine wraps 3->0 and refetches instr[0]
        do_reset();
        for (int i = 0; i < 4; i++) imem2[i] = ins(8'h10, 8'(8'h20 + i), 8'h01, 8'h02);
        f0c = fetch0_cnt;
        w0  = wrap_cnt;
        @(negedge Clk);
        run2 = 1'b1;
        k = 0;
        while ((fetch0_cnt - f0c) < 2 && k < 300) begin @(negedge Clk); k++; end
        @(negedge Clk);
        chk("t6_refetch", DW'(fetch0_cnt - f0c), 2);
        chk("t6_wrap", DW'(wrap_cnt - w0), 1);
        chk("t6_pc", DW'(pc2), 0);
        chk("t6_flags", DW'({busy2, halted2, error2}), DW'(3'b100));
        do_reset();

        chk("rw_overlap", DW'(overlap_cnt), 0);
        chk("wdata_leak", DW'(leak_cnt), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
